// File: rtl/block_main_memory_if.sv
// Memory-side block bus between the data cache (master) and main memory (slave).
interface block_main_memory_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BLOCK_BITS = 256
);
  logic [ADDR_WIDTH-1:0] mem_addr_block;
  logic [BLOCK_BITS-1:0] mem_wdata_block;
  logic                  mem_read;
  logic                  mem_write;
  logic [BLOCK_BITS-1:0] mem_rdata_block;
  logic                  mem_ready;
  logic                  mem_busy;

  modport master (
    output mem_addr_block, mem_wdata_block, mem_read, mem_write,
    input  mem_rdata_block, mem_ready, mem_busy
  );

  modport slave (
    input  mem_addr_block, mem_wdata_block, mem_read, mem_write,
    output mem_rdata_block, mem_ready, mem_busy
  );
endinterface

// File: rtl/block_main_memory.sv
// Main-memory model serving whole-block reads and write-backs with a programmable latency.
// Define MAIN_MEM_STATS_EN to add saturating read/write/dropped-request counters.
module block_main_memory #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_BYTES = 32,
  parameter int unsigned MEM_BYTES   = 4096,
  parameter int unsigned LATENCY     = 4,
  parameter string       INIT_FILE   = ""
) (
  input logic                clk,
  input logic                rst,
  block_main_memory_if.slave bus
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0]        stat_reads,
  output logic [15:0]        stat_writes,
  output logic [15:0]        stat_dropped
`endif
);

  localparam int unsigned WORD_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BLOCK_WORDS = BLOCK_BYTES / WORD_BYTES;
  localparam int unsigned BLOCK_BITS  = BLOCK_BYTES * 8;
  localparam int unsigned MEM_WORDS   = MEM_BYTES / WORD_BYTES;
  localparam int unsigned MEM_AW      = $clog2(MEM_BYTES);
  localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES);
  localparam int unsigned BLK_W       = MEM_AW - OFF_W;
  localparam int unsigned BW_W        = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic [BLOCK_BITS-1:0] rdata_q, rdata_d;

  logic                  req;
  logic                  accept;
  logic                  commit;
  logic [BLK_W-1:0]      commit_blk;
  logic [BLOCK_BITS-1:0] commit_wdata;
  logic                  commit_wr;
  logic [BLOCK_BITS-1:0] rd_block;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Only the block-index bits are decoded; the rest is intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^bus.mem_addr_block;

  assign req = bus.mem_read | bus.mem_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          blk_d   = bus.mem_addr_block[MEM_AW-1:OFF_W];
          wdata_d = bus.mem_wdata_block;
          is_wr_d = bus.mem_write;
          cnt_d   = CntInit;
          if (LATENCY == 1) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With single-cycle latency the commit happens on the accept edge, so take the live request.
  always_comb begin
    commit_blk   = blk_q;
    commit_wdata = wdata_q;
    commit_wr    = is_wr_q;
    if (state_q == StIdle) begin
      commit_blk   = bus.mem_addr_block[MEM_AW-1:OFF_W];
      commit_wdata = bus.mem_wdata_block;
      commit_wr    = bus.mem_write;
    end
  end

  always_comb begin
    rd_block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      rd_block[i*DATA_WIDTH +: DATA_WIDTH] = mem[{commit_blk, BW_W'(i)}];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (commit && !commit_wr) begin
      rdata_d = rd_block;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      blk_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (commit && commit_wr && !rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        mem[{commit_blk, BW_W'(i)}] <= commit_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.mem_ready       = (state_q == StResp);
  assign bus.mem_busy        = (state_q != StIdle);
  assign bus.mem_rdata_block = rdata_q;

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] reads_q, writes_q, dropped_q;
  logic        drop_evt;

  // Busy-time requests and reads shadowed by a simultaneous write are mutually exclusive.
  assign drop_evt = (req && (state_q != StIdle)) || (accept && bus.mem_read && bus.mem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reads_q   <= '0;
      writes_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (commit && !commit_wr && (reads_q != '1)) begin
        reads_q <= reads_q + 16'd1;
      end
      if (commit && commit_wr && (writes_q != '1)) begin
        writes_q <= writes_q + 16'd1;
      end
      if (drop_evt && (dropped_q != '1)) begin
        dropped_q <= dropped_q + 16'd1;
      end
    end
  end

  assign stat_reads   = reads_q;
  assign stat_writes  = writes_q;
  assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_block_main_memory.sv
// Scoreboard bench for block_main_memory: directed scenarios plus random traffic against
// a block-level reference model.
module tb_block_main_memory;
  localparam int unsigned LAT = 4;
  localparam int unsigned BB  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_main_memory_if #(.ADDR_WIDTH(16), .BLOCK_BITS(BB)) ifc ();

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_dropped;
`endif

  block_main_memory #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
`ifdef MAIN_MEM_STATS_EN
    ,
    .stat_reads   (stat_reads),
    .stat_writes  (stat_writes),
    .stat_dropped (stat_dropped)
`endif
  );

  typedef struct {
    bit            is_rd;
    logic [BB-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [BB-1:0] ref_blk [128];
  int            free_at = 0;
  int            last_issue = -100;
  logic [BB-1:0] held = '0;
  logic [15:0]   pool [8];

  task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int blk_of(input logic [15:0] a);
    return (int'(a) % 4096) / 32;
  endfunction

  function automatic logic [BB-1:0] rnd_blk();
    logic [BB-1:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One call occupies exactly one cycle; the model decides acceptance from the busy window.
  task automatic drive(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [BB-1:0] data, input bit commit);
    @(posedge clk);
    #1;
    ifc.mem_read        = rd;
    ifc.mem_write       = wr;
    ifc.mem_addr_block  = addr;
    ifc.mem_wdata_block = data;
    if ((rd || wr) && cyc >= free_at) begin
      last_issue = cyc;
      free_at    = cyc + LAT + 1;
      if (commit) begin
        exp_t e;
        e.due = cyc + LAT;
        if (wr) begin
          ref_blk[blk_of(addr)] = data;
          e.is_rd = 1'b0;
          e.data  = '0;
        end else begin
          e.is_rd = 1'b1;
          e.data  = ref_blk[blk_of(addr)];
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    bit rd_seen;
    rd_seen = 1'b0;
    if (rst) begin
      held = '0;
      chk("reset_ready", BB'(ifc.mem_ready), '0);
      chk("reset_busy", BB'(ifc.mem_busy), '0);
      chk("reset_rdata", ifc.mem_rdata_block, '0);
    end else begin
      chk("busy", BB'(ifc.mem_busy), BB'((cyc > last_issue) && (cyc < free_at)));
      if (ifc.mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: ready=1 at cycle %0d with no request pending", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_cycle", BB'(cyc), BB'(e.due));
          if (e.is_rd) begin
            chk("read_data", ifc.mem_rdata_block, e.data);
            held    = e.data;
            rd_seen = 1'b1;
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_ready: none by cycle %0d, due at cycle %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (!rd_seen) chk("rdata_hold", ifc.mem_rdata_block, held);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [BB-1:0] pat;
    ifc.mem_read        = 1'b0;
    ifc.mem_write       = 1'b0;
    ifc.mem_addr_block  = '0;
    ifc.mem_wdata_block = '0;
    pool = '{16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h0fe0, 16'h0020};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Give every pool block known contents.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, pool[i], rnd_blk(), 1'b1);
      idle(LAT);
    end

    // Known pattern write then read back.
    for (int i = 0; i < 8; i++) pat[i*32 +: 32] = 32'h11111111 * (i + 1);
    drive(1'b0, 1'b1, 16'h0040, pat, 1'b1);
    idle(LAT);
    drive(1'b1, 1'b0, 16'h0040, '0, 1'b1);
    idle(LAT);

    // Unaligned read returns the containing block, then holds.
    drive(1'b1, 1'b0, 16'h0044, '0, 1'b1);
    idle(LAT + 5);

    // Address wraps modulo the storage size.
    drive(1'b0, 1'b1, 16'h1040, rnd_blk(), 1'b1);
    idle(LAT);
    drive(1'b1, 1'b0, 16'h0040, '0, 1'b1);
    idle(LAT);

    // Write-back followed by a read in the cycle right after ready.
    drive(1'b0, 1'b1, 16'h0100, rnd_blk(), 1'b1);
    idle(LAT);
    drive(1'b1, 1'b0, 16'h0100, '0, 1'b1);
    idle(LAT);

    // Requests while busy and in the ready cycle are ignored.
    drive(1'b1, 1'b0, 16'h0080, '0, 1'b1);
    drive(1'b1, 1'b0, 16'h0200, '0, 1'b1);
    drive(1'b0, 1'b1, 16'h0200, rnd_blk(), 1'b1);
    idle(1);
    drive(1'b1, 1'b0, 16'h0400, '0, 1'b1);
    idle(LAT);

    // Simultaneous read and write: only the write is served.
    drive(1'b1, 1'b1, 16'h0800, rnd_blk(), 1'b1);
    idle(LAT);
    drive(1'b1, 1'b0, 16'h0800, '0, 1'b1);
    idle(LAT);

    // Reset in the middle of a write aborts it; old contents survive.
    drive(1'b0, 1'b1, 16'h0080, rnd_blk(), 1'b0);
    idle(2);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    free_at = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(LAT + 2);
    drive(1'b1, 1'b0, 16'h0080, '0, 1'b1);
    idle(LAT);

    // Random traffic with aliasing upper bits and random offsets.
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [15:0] a;
      r = $urandom_range(0, 5);
      a = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 31))
          | 16'($urandom_range(0, 15) << 12);
      case (r)
        0:       drive(1'b1, 1'b0, a, '0, 1'b1);
        1:       drive(1'b0, 1'b1, a, rnd_blk(), 1'b1);
        2:       drive(1'b1, 1'b1, a, rnd_blk(), 1'b1);
        default: idle(1);
      endcase
    end

    idle(LAT + 3);
    chk("scoreboard_empty", BB'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
